// File: rtl/instr_mem_loader.sv
// Loadable synchronous instruction memory: filled through a valid/ready load port,
// then serves registered, stallable fetches with out-of-range/misalignment flagging.
module instr_mem_loader #(
  parameter int             N         = 32,
  parameter int             DEPTH     = 64,
  parameter int             ADDR_W    = 32,
  parameter bit             BYTE_ADDR = 1'b1,
  parameter logic [N-1:0]   NOP       = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [N-1:0]               load_data,
  input  logic                       load_last,
  output logic                       load_ready,
  output logic [$clog2(DEPTH):0]     load_count,
  output logic                       run,
  input  logic                       fetch_req,
  input  logic [ADDR_W-1:0]          fetch_addr,
  input  logic                       stall,
  output logic [N-1:0]               instr,
  output logic                       instr_valid,
  output logic                       addr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [CW-1:0]     load_count_q, load_count_d;
  logic [N-1:0]      instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              addr_err_q, addr_err_d;
  logic              wr_en_s;
  logic [ADDR_W-1:0] fetch_idx_s;
  logic              fetch_bad_s;

  logic [N-1:0]      mem [DEPTH];

  // Word index and error decode for the current fetch address
  always_comb begin
    fetch_idx_s = BYTE_ADDR ? (fetch_addr >> 2) : fetch_addr;
    fetch_bad_s = (fetch_idx_s >= ADDR_W'(DEPTH)) ||
                  (BYTE_ADDR && (fetch_addr[1:0] != 2'b00));
  end

  // Next-state, load bookkeeping and fetch result
  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    load_count_d  = load_count_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    addr_err_d    = 1'b0;
    wr_en_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d      = LOAD;
          wptr_d       = {AW{1'b0}};
          load_count_d = {CW{1'b0}};
        end
      end
      LOAD: begin
        // A restart wins over a same-cycle data word, which is discarded
        if (load_start) begin
          wptr_d       = {AW{1'b0}};
          load_count_d = {CW{1'b0}};
        end else if (load_valid) begin
          wr_en_s      = 1'b1;
          wptr_d       = wptr_q + AW'(1'b1);
          load_count_d = load_count_q + CW'(1'b1);
          if (load_last || (wptr_q == AW'(DEPTH - 1))) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (load_start) begin
          state_d      = LOAD;
          wptr_d       = {AW{1'b0}};
          load_count_d = {CW{1'b0}};
        end else if (stall) begin
          instr_valid_d = instr_valid_q;
          addr_err_d    = addr_err_q;
        end else if (fetch_req) begin
          instr_valid_d = 1'b1;
          addr_err_d    = fetch_bad_s;
          instr_d       = fetch_bad_s ? NOP : mem[fetch_idx_s[AW-1:0]];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and fetch-output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wptr_q        <= {AW{1'b0}};
      load_count_q  <= {CW{1'b0}};
      instr_q       <= NOP;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      load_count_q  <= load_count_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

  // Instruction array: never cleared, only loaded words change
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wptr_q] <= load_data;
    end
  end

  assign load_ready  = (state_q == LOAD);
  assign run         = (state_q == RUN);
  assign load_count  = load_count_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed vector table, corner-case
// sequences and randomized traffic against an abstract memory/loader model.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start, load_valid, load_last, fetch_req, stall;
  logic [31:0] load_data, fetch_addr, fetch_addr2;
  logic        load_ready, run, instr_valid, addr_err;
  logic [6:0]  load_count;
  logic [31:0] instr;
  logic        load_ready2, run2, instr_valid2, addr_err2;
  logic [6:0]  load_count2;
  logic [31:0] instr2;

  always #5 clk = ~clk;

  instr_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .load_count(load_count), .run(run), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .stall(stall), .instr(instr), .instr_valid(instr_valid), .addr_err(addr_err)
  );

  instr_mem_loader #(.BYTE_ADDR(1'b0)) dut_word (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready2),
    .load_count(load_count2), .run(run2), .fetch_req(fetch_req), .fetch_addr(fetch_addr2),
    .stall(stall), .instr(instr2), .instr_valid(instr_valid2), .addr_err(addr_err2)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: what the memory holds and what the fetch port should show
  bit          m_loading, m_running, m_valid, m_err, m_instr_known;
  int          m_count;
  logic [31:0] m_instr;
  logic [31:0] m_mem [64];
  bit          m_known [64];

  typedef struct {
    logic        fr;
    logic        st;
    logic [31:0] fa;
    logic [31:0] ei;
    logic        ev;
    logic        ee;
  } vec_t;
  vec_t tv [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 1'b0; m_running = 1'b0; m_count = 0;
    m_instr = 32'h0; m_instr_known = 1'b1; m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    int  idx;
    bit  bad;
    if (m_running && load_start) begin
      m_running = 1'b0; m_loading = 1'b1; m_count = 0; m_valid = 1'b0; m_err = 1'b0;
    end else if (m_running) begin
      if (!stall) begin
        if (fetch_req) begin
          bad = (fetch_addr / 32'd4 >= 32'd64) || (fetch_addr % 32'd4 != 32'd0);
          m_valid = 1'b1;
          m_err = bad;
          if (bad) begin
            m_instr = 32'h0; m_instr_known = 1'b1;
          end else begin
            idx = int'(fetch_addr / 32'd4);
            m_instr = m_mem[idx]; m_instr_known = m_known[idx];
          end
        end else begin
          m_valid = 1'b0; m_err = 1'b0;
        end
      end
    end else begin
      m_valid = 1'b0; m_err = 1'b0;
      if (load_start) begin
        m_loading = 1'b1; m_count = 0;
      end else if (m_loading && load_valid) begin
        m_mem[m_count] = load_data;
        m_known[m_count] = 1'b1;
        m_count++;
        if (load_last || m_count == 64) begin
          m_loading = 1'b0; m_running = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("load_ready", {31'd0, load_ready}, {31'd0, m_loading});
    chk("run", {31'd0, run}, {31'd0, m_running});
    chk("load_count", {25'd0, load_count}, m_count);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    chk("addr_err", {31'd0, addr_err}, {31'd0, m_err});
    if (m_instr_known) chk("instr", instr, m_instr);
  endtask

  task automatic setin(input logic ls, input logic lv, input logic [31:0] ld,
                       input logic ll, input logic fr, input logic [31:0] fa, input logic st);
    load_start = ls; load_valid = lv; load_data = ld; load_last = ll;
    fetch_req = fr; fetch_addr = fa; stall = st;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [31:0] words [4];
    words[0] = 32'h00221820; words[1] = 32'h00263822;
    words[2] = 32'h00A11024; words[3] = 32'h00CC1025;

    tv[0]  = '{1'b1, 1'b0, 32'h0,   32'h00221820, 1'b1, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 32'h4,   32'h00263822, 1'b1, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 32'h8,   32'h00A11024, 1'b1, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 32'hC,   32'h00CC1025, 1'b1, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 32'h0,   32'h00CC1025, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 32'h4,   32'h00263822, 1'b1, 1'b0};
    tv[6]  = '{1'b1, 1'b1, 32'h8,   32'h00263822, 1'b1, 1'b0};
    tv[7]  = '{1'b1, 1'b1, 32'h8,   32'h00263822, 1'b1, 1'b0};
    tv[8]  = '{1'b1, 1'b1, 32'h8,   32'h00263822, 1'b1, 1'b0};
    tv[9]  = '{1'b1, 1'b0, 32'h8,   32'h00A11024, 1'b1, 1'b0};
    tv[10] = '{1'b1, 1'b0, 32'h100, 32'h00000000, 1'b1, 1'b1};
    tv[11] = '{1'b1, 1'b0, 32'h6,   32'h00000000, 1'b1, 1'b1};
    tv[12] = '{1'b1, 1'b1, 32'h0,   32'h00000000, 1'b1, 1'b1};
    tv[13] = '{1'b1, 1'b0, 32'h0,   32'h00221820, 1'b1, 1'b0};

    for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
    fetch_addr2 = 32'h0;
    setin(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Fetches are ignored while idle
    setin(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    step();

    // Load four words, last flagged on the fourth
    setin(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      setin(1'b0, 1'b1, words[i], (i == 3), 1'b0, 32'h0, 1'b0);
      step();
    end
    chk("count_after_4", {25'd0, load_count}, 32'd4);
    chk("run_after_4", {31'd0, run}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      setin(1'b0, 1'b0, 32'h0, 1'b0, tv[i].fr, tv[i].fa, tv[i].st);
      step();
      chk($sformatf("vec%0d_instr", i), instr, tv[i].ei);
      chk($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, {31'd0, tv[i].ev});
      chk($sformatf("vec%0d_err", i), {31'd0, addr_err}, {31'd0, tv[i].ee});
    end

    // Reload while running: same-cycle fetch dropped, then a one-word reload
    setin(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    step();
    chk("reload_valid", {31'd0, instr_valid}, 32'd0);
    chk("reload_ready", {31'd0, load_ready}, 32'd1);
    setin(1'b0, 1'b1, 32'h08000004, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    chk("reload_count", {25'd0, load_count}, 32'd1);
    setin(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    step();
    chk("reload_w0", instr, 32'h08000004);
    setin(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0);
    step();
    chk("reload_w1_stale", instr, 32'h00263822);

    // Stream 70 words with no last flag: writes stop at the top word
    setin(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    for (int i = 0; i < 70; i++) begin
      setin(1'b0, 1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      if (i == 63) chk("full_ready", {31'd0, load_ready}, 32'd0);
    end
    chk("full_count", {25'd0, load_count}, 32'd64);
    chk("full_run", {31'd0, run}, 32'd1);

    // Range edge on both address modes
    setin(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0);
    fetch_addr2 = 32'd63;
    step();
    chk("byte_oob_err", {31'd0, addr_err}, 32'd1);
    chk("word63_err", {31'd0, addr_err2}, 32'd0);
    chk("word63_valid", {31'd0, instr_valid2}, 32'd1);
    chk("word63_instr", instr2, m_mem[63]);
    fetch_addr2 = 32'd64;
    step();
    chk("word64_err", {31'd0, addr_err2}, 32'd1);
    chk("word64_instr", instr2, 32'h0);
    fetch_addr2 = 32'h0;

    // Asynchronous reset in the middle of a load
    setin(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    for (int i = 0; i < 2; i++) begin
      setin(1'b0, 1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("async_rst_instr", instr, 32'h0);
    chk("async_rst_count", {25'd0, load_count}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    setin(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    step();
    chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] fa;
      if ($urandom_range(0, 7) == 0) fa = $urandom_range(0, 32'h10F);
      else fa = {$urandom_range(0, 66), 2'b00};
      setin(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), fa,
            ($urandom_range(0, 3) == 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
